// File: rtl/micro_ctrl_if.sv
// Keypad/button inputs and BCD display/status outputs of the microwave controller.
// The beep member exists only when DONE_BEEP_EN is defined.
interface micro_ctrl_if;
  logic [9:0] teclado;
  logic       comecan;
  logic       paren;
  logic       limpan;
  logic       portafechada;
  logic       m_on;
  logic [3:0] min_bcd;
  logic [3:0] sec_ten_bcd;
  logic [3:0] sec_one_bcd;
  logic       done;
`ifdef DONE_BEEP_EN
  logic       beep;

  modport master (
    output teclado, comecan, paren, limpan, portafechada,
    input  m_on, min_bcd, sec_ten_bcd, sec_one_bcd, done, beep
  );
  modport slave (
    input  teclado, comecan, paren, limpan, portafechada,
    output m_on, min_bcd, sec_ten_bcd, sec_one_bcd, done, beep
  );
`else
  modport master (
    output teclado, comecan, paren, limpan, portafechada,
    input  m_on, min_bcd, sec_ten_bcd, sec_one_bcd, done
  );
  modport slave (
    input  teclado, comecan, paren, limpan, portafechada,
    output m_on, min_bcd, sec_ten_bcd, sec_one_bcd, done
  );
`endif
endinterface

// File: rtl/micro_ctrl.sv
// Microwave control FSM: keypad BCD time entry, 1 s countdown, magnetron gating, door interlock.
// Optional DONE_BEEP_EN adds a registered beep output held for BEEP_TICKS ticks after completion.
module micro_ctrl #(
  parameter int TICK_DIV   = 100,
  parameter int BEEP_TICKS = 3
) (
  input logic         clk,
  input logic         resetn,
  micro_ctrl_if.slave io
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (TICK_DIV < 2 || BEEP_TICKS < 1) begin : g_param_check
    $error("micro_ctrl: TICK_DIV must be >= 2 and BEEP_TICKS >= 1");
  end

  logic [2:0]    state_q, state_d;
  logic [3:0]    min_q, ten_q, one_q;
  logic [3:0]    min_d, ten_d, one_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    key_prev_q;
  logic          m_on_q, done_q;
  logic          key_acc;
  logic [3:0]    key_idx;
  logic          tick, time_nz, start_ok;
  logic [11:0]   dec_val;

  // Digit-wise borrow: the tens digit is not limited to 0..5, so 0:90 -> 0:89.
  function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] t,
                                          input logic [3:0] o);
    if (o != 4'd0)      return {m, t, o - 4'd1};
    else if (t != 4'd0) return {m, t - 4'd1, 4'd9};
    else                return {m - 4'd1, 4'd5, 4'd9};
  endfunction

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 10; i++)
      if (io.teclado[i]) key_idx = 4'(i);
  end

  assign key_acc  = $onehot(io.teclado) && (key_prev_q == 10'd0);
  assign tick     = (pre_q == PRE_MAX);
  assign time_nz  = ({min_q, ten_q, one_q} != 12'd0);
  assign start_ok = !io.comecan && io.paren && io.portafechada;
  assign dec_val  = bcd_dec(min_q, ten_q, one_q);

`ifdef DONE_BEEP_EN
  localparam int BW = $clog2(BEEP_TICKS + 1);
  logic          beep_q;
  logic [BW-1:0] beep_cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    ten_d   = ten_q;
    one_d   = one_q;
    pre_d   = pre_q;
    if (!io.limpan || state_q > S_DONE) begin
      state_d = S_IDLE;
      {min_d, ten_d, one_d} = 12'd0;
    end else begin
      case (state_q)
        S_IDLE, S_SET: begin
          if (key_acc) begin
            state_d = S_SET;
            {min_d, ten_d, one_d} = {ten_q, one_q, key_idx};
          end else if (state_q == S_SET && start_ok && time_nz) begin
            state_d = S_COOK;
            pre_d   = '0;
          end
        end
        S_COOK: begin
          // Every cycle spent cooking counts, including the one that triggers a pause.
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) {min_d, ten_d, one_d} = dec_val;
          if (tick && dec_val == 12'd0)             state_d = S_DONE;
          else if (!io.paren || !io.portafechada)   state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (start_ok) state_d = S_COOK;
        end
        default: begin
`ifdef DONE_BEEP_EN
          if (beep_q) pre_d = tick ? '0 : pre_q + 1'b1;
`endif
          if (!io.portafechada) begin
            state_d = S_IDLE;
          end else if (key_acc) begin
            state_d = S_SET;
            {min_d, ten_d, one_d} = {8'd0, key_idx};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      min_q      <= 4'd0;
      ten_q      <= 4'd0;
      one_q      <= 4'd0;
      pre_q      <= '0;
      key_prev_q <= 10'd0;
      m_on_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      ten_q      <= ten_d;
      one_q      <= one_d;
      pre_q      <= pre_d;
      key_prev_q <= io.teclado;
      m_on_q     <= (state_d == S_COOK);
      done_q     <= (state_d == S_DONE);
    end
  end

`ifdef DONE_BEEP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else if (state_d == S_DONE && state_q != S_DONE) begin
      beep_q     <= 1'b1;
      beep_cnt_q <= '0;
    end else if (state_d != S_DONE) begin
      beep_q     <= 1'b0;
    end else if (beep_q && tick) begin
      if (beep_cnt_q == BW'(BEEP_TICKS - 1)) beep_q <= 1'b0;
      beep_cnt_q <= beep_cnt_q + 1'b1;
    end
  end

  assign io.beep = beep_q;
`endif

  assign io.m_on        = m_on_q;
  assign io.done        = done_q;
  assign io.min_bcd     = min_q;
  assign io.sec_ten_bcd = ten_q;
  assign io.sec_one_bcd = one_q;
endmodule

// File: tb/tb_micro_ctrl.sv
// Bench for micro_ctrl: directed oven scenarios plus random keypad/button traffic,
// every cycle compared against a time-value reference model.
module tb_micro_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int BEEP_TICKS = 3;
  localparam int M_IDLE = 0, M_SET = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  micro_ctrl_if io ();
  micro_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_TICKS(BEEP_TICKS)) dut (
    .clk(clk), .resetn(resetn), .io(io)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: cook time held as a plain decimal number mmss-style (e.g. 100 = 1:00).
  int         mode, n, ph, bph, bticks;
  logic [9:0] prev;
  logic       m_beep;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dec_time(input int v);
    return (v % 100 != 0) ? v - 1 : v - 41;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] digs();
    return {io.min_bcd, io.sec_ten_bcd, io.sec_one_bcd};
  endfunction

  task automatic model_reset();
    mode = M_IDLE; n = 0; ph = 0; prev = '0;
    m_beep = 1'b0; bph = 0; bticks = 0;
  endtask

  task automatic model_step(input logic [9:0] tec, input logic com, input logic par,
                            input logic lim, input logic door);
    bit key_ok;
    int k, was;
    key_ok = $onehot(tec) && (prev == 10'd0);
    k = 0;
    for (int i = 0; i < 10; i++) if (tec[i]) k = i;
    prev = tec;
    was  = mode;
    if (!lim) begin
      mode = M_IDLE; n = 0;
    end else begin
      case (mode)
        M_IDLE:  if (key_ok) begin mode = M_SET; n = k; end
        M_SET: begin
          if (key_ok) n = (n % 100) * 10 + k;
          else if (!com && par && door && n != 0) begin mode = M_COOK; ph = 0; end
        end
        M_COOK: begin
          ph++;
          if (ph == TICK_DIV) begin
            ph = 0;
            n  = dec_time(n);
            if (n == 0) mode = M_DONE;
            else if (!par || !door) mode = M_PAUSE;
          end else if (!par || !door) mode = M_PAUSE;
        end
        M_PAUSE: if (!com && par && door) mode = M_COOK;
        default: begin
          if (!door) mode = M_IDLE;
          else if (key_ok) begin mode = M_SET; n = k; end
        end
      endcase
    end
    if (mode == M_DONE && was != M_DONE) begin
      m_beep = 1'b1; bph = 0; bticks = 0;
    end else if (mode != M_DONE) begin
      m_beep = 1'b0;
    end else if (m_beep) begin
      bph++;
      if (bph == TICK_DIV) begin
        bph = 0;
        bticks++;
        if (bticks == BEEP_TICKS) m_beep = 1'b0;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    logic [13:0] exp;
    exp = {mode == M_COOK, mode == M_DONE, to_bcd(n)};
    check(tag, {18'd0, io.m_on, io.done, digs()}, {18'd0, exp});
`ifdef DONE_BEEP_EN
    check({tag, "_beep"}, {31'd0, io.beep}, {31'd0, m_beep});
`endif
  endtask

  task automatic step(input logic [9:0] tec, input logic com, input logic par,
                      input logic lim, input logic door);
    io.teclado = tec; io.comecan = com; io.paren = par;
    io.limpan = lim; io.portafechada = door;
    @(posedge clk);
    model_step(tec, com, par, lim, door);
    #1;
    check_outs("cyc");
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic press(input int k);
    logic [9:0] one;
    one = 10'd1;
    step(one << k, 1'b1, 1'b1, 1'b1, 1'b1);
    step(10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic start();
    step(10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic clear();
    step(10'd0, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [9:0] tec;
    io.teclado = '0; io.comecan = 1'b1; io.paren = 1'b1;
    io.limpan = 1'b1; io.portafechada = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {18'd0, io.m_on, io.done, digs()}, 32'd0);
    resetn = 1'b1;

    // Key entry, held key, multi-hot
    press(1); press(0); press(0);
    check("entry_100", digs(), 12'h100);
    repeat (4) step(10'h020, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    check("held_key", digs(), 12'h005);
    step(10'h003, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    check("multi_hot", digs(), 12'h005);
    clear();

    // Cook to completion
    press(3);
    start();
    check("cook_mon", io.m_on, 1);
    idle(4); check("cd_002", digs(), 12'h002);
    idle(4); check("cd_001", digs(), 12'h001);
    idle(4); check("cd_000", digs(), 12'h000);
    check("cd_flags", {io.m_on, io.done}, 2'b01);
    repeat (3) start();
    check("done_hold", {io.m_on, io.done}, 2'b01);
    clear();

    // Borrow chain
    press(1); press(0); press(0);
    start(); idle(4);
    check("borrow_059", digs(), 12'h059);
    clear();
    press(1); press(0);
    start(); idle(4);
    check("borrow_009", digs(), 12'h009);
    clear();

    // Door interlock with resume
    press(5);
    repeat (3) step(10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("door_open_start", io.m_on, 0);
    step(10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("door_closed_start", io.m_on, 1);
    idle(2);
    repeat (3) step(10'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("door_pause", {io.m_on, digs()}, {1'b0, 12'h005});
    step(10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("door_resume", digs(), 12'h005);
    idle(1);
    check("door_tick", digs(), 12'h004);
    clear();

    // Pause then clear
    press(9);
    start(); idle(2);
    repeat (50) step(10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("pause_frozen", {io.m_on, digs()}, {1'b0, 12'h009});
    start();
    check("pause_resume", io.m_on, 1);
    idle(3);
    clear();
    check("clear_all", {io.m_on, io.done, digs()}, 14'd0);

    // Done and beep window
    press(2);
    start(); idle(8);
    check("beep_done", io.done, 1);
`ifdef DONE_BEEP_EN
    check("beep_on", io.beep, 1);
    idle(11);
    check("beep_last", io.beep, 1);
    idle(1);
    check("beep_off", io.beep, 0);
`endif
    clear();

    // Asynchronous reset mid-cook
    press(5);
    start(); idle(2);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst", {io.m_on, io.done, digs()}, 14'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      tec = 10'd0;
      else if (r < 90) begin tec = 10'd1; tec = tec << $urandom_range(0, 9); end
      else             tec = 10'($urandom_range(1, 1023));
      step(tec, ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1,
                ($urandom_range(0, 99) < 6)  ? 1'b0 : 1'b1,
                ($urandom_range(0, 99) < 2)  ? 1'b0 : 1'b1,
                ($urandom_range(0, 99) < 6)  ? 1'b0 : 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/micro_ctrl.md
Name: micro_ctrl

Overview:
- Control FSM for the microwave oven: captures keypad digits into a BCD cook time, runs a 1 s countdown, gates the magnetron, and enforces the door interlock.
- Sits between the keypad/button inputs and the 7-segment decoders; outputs raw BCD digits, with segment decoding done downstream.

Parameters:
- TICK_DIV, 100, clk cycles per 1 s countdown tick (100 Hz system clock); legal values >= 2.
- BEEP_TICKS, 3, length of the done beep in ticks; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- teclado  input  10  keypad, one-hot; bit i = digit i.
- comecan  input  1  start, active-low, level-sensitive.
- paren  input  1  stop/pause, active-low.
- limpan  input  1  clear, active-low.
- portafechada  input  1  1 = door closed.
- m_on  output  1  magnetron enable, registered.
- min_bcd  output  4  minutes digit.
- sec_ten_bcd  output  4  seconds-tens digit.
- sec_one_bcd  output  4  seconds-ones digit.
- done  output  1  cook cycle completed, registered.

Behaviour:
- Reset: state IDLE; m_on=0, done=0, all digits 0, prescaler 0, key-edge register 0.
- All inputs are synchronous to clk. All outputs are registered; a change takes effect the cycle after the condition is sampled.
- Key accept:
  - A key is accepted when teclado is exactly one-hot and the previous-cycle teclado was all-zero.
  - Multi-hot or held values are ignored; a key must be released to all-zero before the next one is accepted.
- Digit shift on accepted key: min<=sec_ten, sec_ten<=sec_one, sec_one<=key index. The old min is discarded.
- Tens digit is not range-limited: 0:90 counts 90 s.
- Input priority every state: limpan=0 > paren=0 > portafechada=0 > comecan=0.
- States:
  - IDLE: digits all 0. Accepted key -> SET with shifted digits. Start is ignored.
  - SET: accepted key shifts digits.
    - limpan=0 -> IDLE, digits cleared.
    - comecan=0 & paren=1 & portafechada=1 & time!=0 -> COOK, prescaler cleared.
  - COOK: m_on=1; keys ignored.
    - Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and issues a tick.
    - Tick decrement: if sec_one!=0, sec_one-1. Else if sec_ten!=0, sec_ten-1 and sec_one=9. Else min-1, sec_ten=5, sec_one=9.
    - If a tick decrements to 0:00 -> DONE, with m_on=0 and done=1 in the same registered update.
    - paren=0 or portafechada=0 -> PAUSE, m_on=0 next cycle, prescaler holds its value.
    - limpan=0 -> IDLE, digits cleared.
  - PAUSE: m_on=0; digits and prescaler hold; keys ignored.
    - limpan=0 -> IDLE.
    - comecan=0 & paren=1 & portafechada=1 -> COOK; the prescaler resumes from the held count.
  - DONE: digits 0, done=1; the level-held comecan cannot restart because time=0.
    - limpan=0 or portafechada=0 -> IDLE, done=0.
    - Accepted key -> SET, done=0, sec_one=key.
- Simultaneous events:
  - A tick in the same cycle as a pause condition: the decrement is applied, then the state moves to PAUSE.
  - A tick reaching 0:00 in the same cycle as limpan=0: the result is IDLE.
- Asynchronous reset mid-COOK: m_on drops immediately (asynchronously) and all state clears.

Optional Feature:
- Macro DONE_BEEP_EN.
- When defined: adds output port beep (1 bit, registered). beep=1 from entry into DONE for BEEP_TICKS ticks; the prescaler runs in DONE for this count. beep clears early on leaving DONE.
- When undefined: no beep port and no beep logic; the prescaler is idle in DONE.

Test Plan:
- Entry: press keys 1, 0, 0, each separated by all-zero -> digits 1:00. Hold key 5 for 4 cycles -> exactly one shift. Apply multi-hot 0000000011 -> no change.
- Cook to completion (TICK_DIV=4): enter 0:03, door=1, comecan=0 -> m_on=1 after 1 cycle. Digits go 0:02, 0:01, 0:00 at 4-cycle intervals. m_on=0 and done=1 with 0:00.
- Borrow chain (TICK_DIV=4): enter 1:00, cook -> 0:59 after first tick; enter 0:10 -> 0:09.
- Interlock: enter 0:05, comecan=0 with door=0 -> no cooking. Close door -> COOK. Open door mid-count -> m_on=0, digits hold. Close door -> resumes without a lost or extra tick.
- Pause/clear: paren=0 for 50 cycles mid-cook -> digits frozen, m_on=0. paren=1 with comecan=0 -> resume. limpan=0 -> 0:00, IDLE, m_on=0.
- Reset: assert resetn=0 mid-COOK -> m_on=0 with no clk edge; all digits 0; done=0. With DONE_BEEP_EN: beep high for 3 ticks after done.
